// File: rtl/mat_switch_endpoint.sv
// Buffered endpoint between mat control and the inter-core switch: a send FIFO of
// (dest idx, vector) entries and a one-outstanding-request receive path into a recv FIFO.
module mat_switch_endpoint #(
  parameter int SWITCH_WIDTH          = 16,
  parameter int SWITCH_CORE_SIZE      = 4,
  parameter int SEND_DEPTH            = 4,
  parameter int RECV_DEPTH            = 4,
  parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             core_send_valid,
  input  logic [SWITCH_CORE_ADDR_SIZE-1:0] core_send_core_idx,
  input  logic [SWITCH_WIDTH*32-1:0]       core_send_data,
  output logic                             core_send_ready,
  output logic                             switch_send_ready,
  output logic [SWITCH_CORE_ADDR_SIZE-1:0] switch_send_core_idx,
  output logic [SWITCH_WIDTH*32-1:0]       switch_send_data,
  input  logic                             switch_send_ok,
  input  logic                             core_recv_req,
  input  logic [SWITCH_CORE_ADDR_SIZE-1:0] core_recv_core_idx,
  output logic                             core_recv_ack,
  output logic                             switch_recv_request,
  output logic [SWITCH_CORE_ADDR_SIZE-1:0] switch_recv_core_idx,
  input  logic                             switch_recv_ready,
  input  logic [SWITCH_WIDTH*32-1:0]       switch_recv_data,
  output logic                             core_recv_valid,
  output logic [SWITCH_WIDTH*32-1:0]       core_recv_data,
  input  logic                             core_recv_pop,
  output logic                             idle
);

  localparam int DW = SWITCH_WIDTH * 32;
  localparam int CA = SWITCH_CORE_ADDR_SIZE;
  localparam int SP = $clog2(SEND_DEPTH);
  localparam int RP = $clog2(RECV_DEPTH);
  localparam logic [SP:0] L_SEND_FULL = SEND_DEPTH[SP:0];
  localparam logic [RP:0] L_RECV_FULL = RECV_DEPTH[RP:0];

  typedef enum logic {R_IDLE, R_WAIT} recv_state_t;

  // Send FIFO (lanes are shortreal values carried as raw IEEE-754 bits)
  logic [CA-1:0] r_send_idx_mem [SEND_DEPTH];
  logic [DW-1:0] r_send_data_mem [SEND_DEPTH];
  logic [SP-1:0] r_send_wr_ptr, r_send_rd_ptr;
  logic [SP:0]   r_send_count;
  logic          w_send_push, w_send_pop;

  // Recv path
  logic [DW-1:0] r_recv_mem [RECV_DEPTH];
  logic [RP-1:0] r_recv_wr_ptr, r_recv_rd_ptr;
  logic [RP:0]   r_recv_count;
  logic          w_recv_wr, w_recv_pop;
  recv_state_t   r_state, w_state_next;
  logic [CA-1:0] r_recv_idx;

  // Ready is taken from the count alone so a full FIFO refuses a push even when the head leaves.
  assign core_send_ready      = (r_send_count != L_SEND_FULL);
  assign switch_send_ready    = (r_send_count != '0);
  assign w_send_push          = core_send_valid & core_send_ready;
  assign w_send_pop           = switch_send_ready & switch_send_ok;
  assign switch_send_core_idx = switch_send_ready ? r_send_idx_mem[r_send_rd_ptr] : '0;
  assign switch_send_data     = switch_send_ready ? r_send_data_mem[r_send_rd_ptr] : '0;

  // NOTE: storage arrays carry no reset; only pointers and counts define validity.
  always_ff @(posedge clock) begin
    if (w_send_push) begin
      r_send_idx_mem[r_send_wr_ptr]  <= core_send_core_idx;
      r_send_data_mem[r_send_wr_ptr] <= core_send_data;
    end
    if (w_recv_wr) r_recv_mem[r_recv_wr_ptr] <= switch_recv_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_send_wr_ptr <= '0;
      r_send_rd_ptr <= '0;
      r_send_count  <= '0;
    end else begin
      if (w_send_push) r_send_wr_ptr <= r_send_wr_ptr + 1'b1;
      if (w_send_pop)  r_send_rd_ptr <= r_send_rd_ptr + 1'b1;
      case ({w_send_push, w_send_pop})
        2'b10:   r_send_count <= r_send_count + 1'b1;
        2'b01:   r_send_count <= r_send_count - 1'b1;
        default: r_send_count <= r_send_count;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next  = r_state;
    core_recv_ack = 1'b0;
    w_recv_wr     = 1'b0;
    case (r_state)
      R_IDLE: begin
        // Space is reserved at ack, so the eventual delivery always fits.
        core_recv_ack = core_recv_req & (r_recv_count != L_RECV_FULL);
        if (core_recv_ack) w_state_next = R_WAIT;
      end
      R_WAIT: begin
        if (switch_recv_ready) begin
          w_recv_wr    = 1'b1;
          w_state_next = R_IDLE;
        end
      end
      default: w_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= R_IDLE;
      r_recv_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if (core_recv_ack) r_recv_idx <= core_recv_core_idx;
    end
  end

  assign switch_recv_request  = (r_state == R_WAIT);
  assign switch_recv_core_idx = switch_recv_request ? r_recv_idx : '0;

  assign core_recv_valid = (r_recv_count != '0);
  assign w_recv_pop      = core_recv_pop & core_recv_valid;
  assign core_recv_data  = core_recv_valid ? r_recv_mem[r_recv_rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_recv_wr_ptr <= '0;
      r_recv_rd_ptr <= '0;
      r_recv_count  <= '0;
    end else begin
      if (w_recv_wr)  r_recv_wr_ptr <= r_recv_wr_ptr + 1'b1;
      if (w_recv_pop) r_recv_rd_ptr <= r_recv_rd_ptr + 1'b1;
      case ({w_recv_wr, w_recv_pop})
        2'b10:   r_recv_count <= r_recv_count + 1'b1;
        2'b01:   r_recv_count <= r_recv_count - 1'b1;
        default: r_recv_count <= r_recv_count;
      endcase
    end
  end

  assign idle = (r_send_count == '0) & (r_recv_count == '0) & (r_state == R_IDLE);

endmodule

// File: tb/tb_mat_switch_endpoint.sv
// Directed bench for mat_switch_endpoint: inputs change on the falling edge,
// outputs are compared 1 ns later against hand-derived values.
module tb_mat_switch_endpoint;

  localparam int SW = 16;
  localparam int CA = 2;
  localparam int DW = SW * 32;

  // IEEE-754 single-precision encodings used as lane0 values
  localparam logic [31:0] F1  = 32'h3F80_0000;  // 1.0
  localparam logic [31:0] F2  = 32'h4000_0000;  // 2.0
  localparam logic [31:0] F3  = 32'h4040_0000;  // 3.0
  localparam logic [31:0] F4  = 32'h4080_0000;  // 4.0
  localparam logic [31:0] F5  = 32'h40A0_0000;  // 5.0
  localparam logic [31:0] F75 = 32'h40F0_0000;  // 7.5

  logic          clock = 1'b0;
  logic          reset;
  logic          core_send_valid;
  logic [CA-1:0] core_send_core_idx;
  logic [DW-1:0] core_send_data;
  logic          core_send_ready;
  logic          switch_send_ready;
  logic [CA-1:0] switch_send_core_idx;
  logic [DW-1:0] switch_send_data;
  logic          switch_send_ok;
  logic          core_recv_req;
  logic [CA-1:0] core_recv_core_idx;
  logic          core_recv_ack;
  logic          switch_recv_request;
  logic [CA-1:0] switch_recv_core_idx;
  logic          switch_recv_ready;
  logic [DW-1:0] switch_recv_data;
  logic          core_recv_valid;
  logic [DW-1:0] core_recv_data;
  logic          core_recv_pop;
  logic          idle;

  int total = 0;
  int bad   = 0;

  mat_switch_endpoint #(
    .SWITCH_WIDTH(SW), .SWITCH_CORE_SIZE(4), .SEND_DEPTH(4), .RECV_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .core_send_valid(core_send_valid), .core_send_core_idx(core_send_core_idx),
    .core_send_data(core_send_data), .core_send_ready(core_send_ready),
    .switch_send_ready(switch_send_ready), .switch_send_core_idx(switch_send_core_idx),
    .switch_send_data(switch_send_data), .switch_send_ok(switch_send_ok),
    .core_recv_req(core_recv_req), .core_recv_core_idx(core_recv_core_idx),
    .core_recv_ack(core_recv_ack), .switch_recv_request(switch_recv_request),
    .switch_recv_core_idx(switch_recv_core_idx), .switch_recv_ready(switch_recv_ready),
    .switch_recv_data(switch_recv_data), .core_recv_valid(core_recv_valid),
    .core_recv_data(core_recv_data), .core_recv_pop(core_recv_pop), .idle(idle)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Full vector: lane0 carries the value, other lanes a pattern derived from it.
  function automatic logic [DW-1:0] vec(input logic [31:0] l0);
    logic [DW-1:0] v;
    v[31:0] = l0;
    for (int k = 1; k < SW; k++) v[k*32 +: 32] = {l0[31:16] ^ 16'h5A5A, 16'(k)};
    return v;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    core_send_valid    = 1'b0;
    core_send_core_idx = '0;
    core_send_data     = '0;
    switch_send_ok     = 1'b0;
    core_recv_req      = 1'b0;
    core_recv_core_idx = '0;
    switch_recv_ready  = 1'b0;
    switch_recv_data   = '0;
    core_recv_pop      = 1'b0;
  endtask

  task automatic push(input logic [CA-1:0] idx, input logic [31:0] l0);
    core_send_valid = 1'b1; core_send_core_idx = idx; core_send_data = vec(l0);
    tick();
    core_send_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1; tick(); tick(); reset = 1'b0; #1;
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL por_idle got=%0h exp=1", idle); end
    total++; if (core_send_ready !== 1'b1) begin bad++; $display("FAIL por_send_ready got=%0h exp=1", core_send_ready); end
    total++; if (switch_send_ready !== 1'b0) begin bad++; $display("FAIL por_sw_send_ready got=%0h exp=0", switch_send_ready); end
    total++; if (core_recv_valid !== 1'b0) begin bad++; $display("FAIL por_recv_valid got=%0h exp=0", core_recv_valid); end
    total++; if (switch_send_data !== '0) begin bad++; $display("FAIL por_send_data got=%0h exp=0", switch_send_data); end
    // Build mid-traffic state: 3 send entries and an outstanding request.
    tick();
    core_recv_req = 1'b1; core_recv_core_idx = 2'd3;
    push(2'd1, F1);
    core_recv_req = 1'b0;
    push(2'd2, F2);
    push(2'd3, F3);
    #1;
    total++; if (switch_recv_request !== 1'b1) begin bad++; $display("FAIL mid_request got=%0h exp=1", switch_recv_request); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL mid_idle got=%0h exp=0", idle); end
    tick();
    reset = 1'b1; tick(); tick(); reset = 1'b0; #1;
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle got=%0h exp=1", idle); end
    total++; if (core_send_ready !== 1'b1) begin bad++; $display("FAIL rst_send_ready got=%0h exp=1", core_send_ready); end
    total++; if (switch_send_ready !== 1'b0) begin bad++; $display("FAIL rst_sw_send_ready got=%0h exp=0", switch_send_ready); end
    total++; if (switch_recv_request !== 1'b0) begin bad++; $display("FAIL rst_request got=%0h exp=0", switch_recv_request); end
    total++; if (switch_recv_core_idx !== 2'd0) begin bad++; $display("FAIL rst_recv_idx got=%0h exp=0", switch_recv_core_idx); end
    tick();
  endtask

  task automatic test_send_fill();
    logic [31:0] vals [4];
    vals[0] = F1; vals[1] = F2; vals[2] = F3; vals[3] = F4;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (core_send_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d got=%0h exp=1", i, core_send_ready); end
      push(2'(i + 1), vals[i]);
    end
    #1;
    total++; if (core_send_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%0h exp=0", core_send_ready); end
    // Fifth push into a full FIFO is dropped; head stays stable while ok=0.
    push(2'd0, F5);
    #1;
    total++; if (switch_send_core_idx !== 2'd1) begin bad++; $display("FAIL fill_head_stable got=%0h exp=1", switch_send_core_idx); end
    for (int i = 0; i < 4; i++) begin
      switch_send_ok = 1'b1; #1;
      total++; if (switch_send_ready !== 1'b1) begin bad++; $display("FAIL drain_ready_%0d got=%0h exp=1", i, switch_send_ready); end
      total++; if (switch_send_core_idx !== 2'(i + 1)) begin bad++; $display("FAIL drain_idx_%0d got=%0h exp=%0h", i, switch_send_core_idx, i + 1); end
      total++; if (switch_send_data !== vec(vals[i])) begin bad++; $display("FAIL drain_data_%0d got=%0h exp=%0h", i, switch_send_data, vec(vals[i])); end
      tick();
    end
    switch_send_ok = 1'b0; #1;
    total++; if (switch_send_ready !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0h exp=0", switch_send_ready); end
    total++; if (core_send_ready !== 1'b1) begin bad++; $display("FAIL drain_send_ready got=%0h exp=1", core_send_ready); end
  endtask

  task automatic test_full_push_pop();
    logic [CA-1:0] exp_idx [4];
    logic [31:0]   exp_val [4];
    exp_idx[0] = 2'd3; exp_idx[1] = 2'd0; exp_idx[2] = 2'd1; exp_idx[3] = 2'd2;
    exp_val[0] = F2;   exp_val[1] = F3;   exp_val[2] = F4;   exp_val[3] = F75;
    push(2'd2, F1);
    for (int i = 0; i < 3; i++) push(exp_idx[i], exp_val[i]);
    // Full: push and pop offered together; only the pop happens.
    core_send_valid = 1'b1; core_send_core_idx = 2'd2; core_send_data = vec(F75);
    switch_send_ok = 1'b1; #1;
    total++; if (core_send_ready !== 1'b0) begin bad++; $display("FAIL pp_refuse got=%0h exp=0", core_send_ready); end
    total++; if (switch_send_core_idx !== 2'd2) begin bad++; $display("FAIL pp_head got=%0h exp=2", switch_send_core_idx); end
    tick();
    switch_send_ok = 1'b0; #1;
    total++; if (core_send_ready !== 1'b1) begin bad++; $display("FAIL pp_after_pop got=%0h exp=1", core_send_ready); end
    tick();
    core_send_valid = 1'b0; #1;
    total++; if (core_send_ready !== 1'b0) begin bad++; $display("FAIL pp_refilled got=%0h exp=0", core_send_ready); end
    for (int i = 0; i < 4; i++) begin
      switch_send_ok = 1'b1; #1;
      total++; if (switch_send_core_idx !== exp_idx[i]) begin bad++; $display("FAIL pp_idx_%0d got=%0h exp=%0h", i, switch_send_core_idx, exp_idx[i]); end
      total++; if (switch_send_data !== vec(exp_val[i])) begin bad++; $display("FAIL pp_data_%0d got=%0h exp=%0h", i, switch_send_data, vec(exp_val[i])); end
      tick();
    end
    switch_send_ok = 1'b0; #1;
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL pp_idle got=%0h exp=1", idle); end
  endtask

  task automatic test_recv();
    core_recv_req = 1'b1; core_recv_core_idx = 2'd2; #1;
    total++; if (core_recv_ack !== 1'b1) begin bad++; $display("FAIL recv_ack got=%0h exp=1", core_recv_ack); end
    total++; if (switch_recv_request !== 1'b0) begin bad++; $display("FAIL recv_req_early got=%0h exp=0", switch_recv_request); end
    tick();
    core_recv_core_idx = 2'd1; #1;
    total++; if (switch_recv_request !== 1'b1) begin bad++; $display("FAIL recv_request got=%0h exp=1", switch_recv_request); end
    total++; if (switch_recv_core_idx !== 2'd2) begin bad++; $display("FAIL recv_idx got=%0h exp=2", switch_recv_core_idx); end
    total++; if (core_recv_ack !== 1'b0) begin bad++; $display("FAIL recv_ack_wait got=%0h exp=0", core_recv_ack); end
    tick();
    core_recv_req = 1'b0;
    tick(); #1;
    total++; if (switch_recv_core_idx !== 2'd2) begin bad++; $display("FAIL recv_idx_stable got=%0h exp=2", switch_recv_core_idx); end
    switch_recv_ready = 1'b1; switch_recv_data = vec(F75); #1;
    total++; if (core_recv_valid !== 1'b0) begin bad++; $display("FAIL recv_valid_early got=%0h exp=0", core_recv_valid); end
    tick();
    switch_recv_ready = 1'b0; switch_recv_data = '0; #1;
    total++; if (core_recv_valid !== 1'b1) begin bad++; $display("FAIL recv_valid got=%0h exp=1", core_recv_valid); end
    total++; if (core_recv_data !== vec(F75)) begin bad++; $display("FAIL recv_data got=%0h exp=%0h", core_recv_data, vec(F75)); end
    total++; if (switch_recv_request !== 1'b0) begin bad++; $display("FAIL recv_req_drop got=%0h exp=0", switch_recv_request); end
    core_recv_pop = 1'b1;
    tick();
    core_recv_pop = 1'b0; #1;
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL recv_idle got=%0h exp=1", idle); end
  endtask

  task automatic test_recv_full();
    logic [31:0] vals [5];
    vals[0] = F1; vals[1] = F2; vals[2] = F3; vals[3] = F4; vals[4] = F5;
    for (int i = 0; i < 4; i++) begin
      core_recv_req = 1'b1; core_recv_core_idx = 2'(i); #1;
      total++; if (core_recv_ack !== 1'b1) begin bad++; $display("FAIL rf_ack_%0d got=%0h exp=1", i, core_recv_ack); end
      tick();
      core_recv_req = 1'b0; switch_recv_ready = 1'b1; switch_recv_data = vec(vals[i]);
      tick();
      switch_recv_ready = 1'b0;
    end
    core_recv_req = 1'b1; core_recv_core_idx = 2'd1; #1;
    total++; if (core_recv_ack !== 1'b0) begin bad++; $display("FAIL rf_full_ack got=%0h exp=0", core_recv_ack); end
    // Pop in the same cycle as the req does not free space for that req.
    core_recv_pop = 1'b1; #1;
    total++; if (core_recv_ack !== 1'b0) begin bad++; $display("FAIL rf_pop_same got=%0h exp=0", core_recv_ack); end
    total++; if (core_recv_data !== vec(vals[0])) begin bad++; $display("FAIL rf_head got=%0h exp=%0h", core_recv_data, vec(vals[0])); end
    tick();
    core_recv_pop = 1'b0; #1;
    total++; if (core_recv_ack !== 1'b1) begin bad++; $display("FAIL rf_ack_after_pop got=%0h exp=1", core_recv_ack); end
    tick();
    core_recv_req = 1'b0; switch_recv_ready = 1'b1; switch_recv_data = vec(vals[4]);
    tick();
    switch_recv_ready = 1'b0;
    for (int i = 1; i < 5; i++) begin
      #1;
      total++; if (core_recv_data !== vec(vals[i])) begin bad++; $display("FAIL rf_order_%0d got=%0h exp=%0h", i, core_recv_data, vec(vals[i])); end
      core_recv_pop = 1'b1;
      tick();
      core_recv_pop = 1'b0;
    end
    #1;
    total++; if (core_recv_valid !== 1'b0) begin bad++; $display("FAIL rf_empty got=%0h exp=0", core_recv_valid); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rf_idle got=%0h exp=1", idle); end
  endtask

  task automatic test_stray_inputs();
    switch_recv_ready = 1'b1; switch_recv_data = vec(F3);
    core_recv_pop = 1'b1; switch_send_ok = 1'b1;
    tick(); tick();
    clear_inputs(); #1;
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL stray_idle got=%0h exp=1", idle); end
    total++; if (core_recv_valid !== 1'b0) begin bad++; $display("FAIL stray_recv_valid got=%0h exp=0", core_recv_valid); end
    total++; if (switch_send_ready !== 1'b0) begin bad++; $display("FAIL stray_send_ready got=%0h exp=0", switch_send_ready); end
    // Counts must be intact: one push then one pop returns to idle.
    push(2'd3, F4);
    #1;
    total++; if (switch_send_core_idx !== 2'd3) begin bad++; $display("FAIL stray_push_idx got=%0h exp=3", switch_send_core_idx); end
    switch_send_ok = 1'b1;
    tick();
    switch_send_ok = 1'b0; #1;
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL stray_final_idle got=%0h exp=1", idle); end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    test_reset();
    test_send_fill();
    test_full_push_pop();
    test_recv();
    test_recv_full();
    test_stray_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
